hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Generates the load-use stall and branch/jump flush controls consumed by the IF/ID and ID/EX stage registers and the PC.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding.
- Sits beside the ID stage; observes ID/EX and EX/MEM stage-register outputs.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_ctrl_load_use_detect.sv | 23 ++
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO          = 5'd0;
  localparam int         FLUSH_CYCLES_DEF  = 1;
  localparam int         MEM_TIMEOUT_DEF   = 255;

  // Saturating increment used by the optional event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    logic [31:0] r;
    r = v;
    if (en && (v != 32'hFFFF_FFFF)) begin
      r = v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegisterRt,
  input  logic [4:0] IF_ID_RegisterRs,
  input  logic [4:0] IF_ID_RegisterRt,
  input  logic       IF_ID_UsesRt,
  output logic       load_use
);

  logic rs_hit_s;
  logic rt_hit_s;

  // $zero is never a real dependency, and rt only matters when it is a source.
  always_comb begin
    rs_hit_s = (ID_EX_RegisterRt == IF_ID_RegisterRs);
    rt_hit_s = IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt);
    load_use = ID_EX_MemRead && (ID_EX_RegisterRt != REG_ZERO) && (rs_hit_s || rt_hit_s);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, branch/jump flush and data-memory freeze.
// Optional event counters are enabled with the HAZARD_STATS_EN macro.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_UsesRt,
  input  logic        MEM_BranchTaken,
  input  logic        MEM_Jump,
  input  logic        MEM_Access,
  input  logic        dmem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_Flush,
  output logic        ID_Hazard_lwstall,
  output logic        ID_Hazard_Branch,
  output logic        pipe_hold,
`ifdef HAZARD_STATS_EN
  output logic [31:0] lwstall_count,
  output logic [31:0] flush_count,
  output logic [31:0] memwait_count,
`endif
  output logic        mem_timeout_err
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_TIMEOUT);

  hz_state_e  state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  logic load_use_s;
  logic redirect_s;
  logic mem_stall_s;

  load_use_detect u_load_use_detect (
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRt (ID_EX_RegisterRt),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .IF_ID_UsesRt     (IF_ID_UsesRt),
    .load_use         (load_use_s)
  );

  assign redirect_s  = MEM_BranchTaken || MEM_Jump;
  assign mem_stall_s = MEM_Access && !dmem_ready;

  // Next-state, counter and output logic; priority is mem_stall > redirect > load_use.
  always_comb begin
    state_d           = state_q;
    flush_cnt_d       = flush_cnt_q;
    wait_cnt_d        = wait_cnt_q;
    err_d             = err_q;
    PC_write          = 1'b1;
    IF_ID_write       = 1'b1;
    IF_Flush          = 1'b0;
    ID_Hazard_lwstall = 1'b0;
    ID_Hazard_Branch  = 1'b0;
    pipe_hold         = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          pipe_hold   = 1'b1;
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          state_d     = MEMWAIT;
          wait_cnt_d  = 8'd1;
        end else if (redirect_s) begin
          IF_Flush         = 1'b1;
          ID_Hazard_Branch = 1'b1;
          flush_cnt_d      = FLUSH_RELOAD;
          state_d          = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
        end else if (load_use_s) begin
          ID_Hazard_lwstall = 1'b1;
          PC_write          = 1'b0;
          IF_ID_write       = 1'b0;
        end else begin
          state_d = RUN;
        end
      end

      FLUSH: begin
        if (mem_stall_s) begin
          // Flush count is left untouched so it resumes after the wait.
          pipe_hold   = 1'b1;
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          state_d     = MEMWAIT;
          wait_cnt_d  = 8'd1;
        end else begin
          IF_Flush         = 1'b1;
          ID_Hazard_Branch = 1'b1;
          if (redirect_s) begin
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
          end else if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end

      MEMWAIT: begin
        if (dmem_ready || (wait_cnt_q >= WAIT_LIMIT)) begin
          if (!dmem_ready) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          wait_cnt_d = 8'd0;
          state_d    = (flush_cnt_q != 3'd0) ? FLUSH : RUN;
        end else begin
          pipe_hold   = 1'b1;
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end
      end

      default: begin
        state_d     = RUN;
        flush_cnt_d = 3'd0;
        wait_cnt_d  = 8'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] lwstall_cnt_q, lwstall_cnt_d;
  logic [31:0] flush_ev_cnt_q, flush_ev_cnt_d;
  logic [31:0] memwait_cnt_q, memwait_cnt_d;

  // Saturating per-cycle event counts.
  always_comb begin
    lwstall_cnt_d  = sat_inc32(lwstall_cnt_q, ID_Hazard_lwstall);
    flush_ev_cnt_d = sat_inc32(flush_ev_cnt_q, IF_Flush);
    memwait_cnt_d  = sat_inc32(memwait_cnt_q, pipe_hold);
  end

  // Event counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lwstall_cnt_q  <= 32'd0;
      flush_ev_cnt_q <= 32'd0;
      memwait_cnt_q  <= 32'd0;
    end else begin
      lwstall_cnt_q  <= lwstall_cnt_d;
      flush_ev_cnt_q <= flush_ev_cnt_d;
      memwait_cnt_q  <= memwait_cnt_d;
    end
  end

  assign lwstall_count = lwstall_cnt_q;
  assign flush_count   = flush_ev_cnt_q;
  assign memwait_count = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=5.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       br;
    logic       jp;
    logic       acc;
    logic       rdy;
  } stim_t;

  // Output vector order: PC_write, IF_ID_write, IF_Flush, lwstall, Branch, pipe_hold, err
  localparam logic [6:0] DEF = 7'b1100000;
  localparam logic [6:0] LWS = 7'b0001000;
  localparam logic [6:0] FLS = 7'b1110100;
  localparam logic [6:0] HLD = 7'b0000010;
  localparam logic [6:0] ERR = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_RegisterRt = 5'd0;
  logic [4:0] IF_ID_RegisterRs = 5'd0;
  logic [4:0] IF_ID_RegisterRt = 5'd0;
  logic       IF_ID_UsesRt = 1'b0;
  logic       MEM_BranchTaken = 1'b0;
  logic       MEM_Jump = 1'b0;
  logic       MEM_Access = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       PC_write, IF_ID_write, IF_Flush, ID_Hazard_lwstall;
  logic       ID_Hazard_Branch, pipe_hold, mem_timeout_err;
`ifdef HAZARD_STATS_EN
  logic [31:0] lwstall_count, flush_count, memwait_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_RegisterRt  (ID_EX_RegisterRt),
    .IF_ID_RegisterRs  (IF_ID_RegisterRs),
    .IF_ID_RegisterRt  (IF_ID_RegisterRt),
    .IF_ID_UsesRt      (IF_ID_UsesRt),
    .MEM_BranchTaken   (MEM_BranchTaken),
    .MEM_Jump          (MEM_Jump),
    .MEM_Access        (MEM_Access),
    .dmem_ready        (dmem_ready),
    .PC_write          (PC_write),
    .IF_ID_write       (IF_ID_write),
    .IF_Flush          (IF_Flush),
    .ID_Hazard_lwstall (ID_Hazard_lwstall),
    .ID_Hazard_Branch  (ID_Hazard_Branch),
    .pipe_hold         (pipe_hold),
`ifdef HAZARD_STATS_EN
    .lwstall_count     (lwstall_count),
    .flush_count       (flush_count),
    .memwait_count     (memwait_count),
`endif
    .mem_timeout_err   (mem_timeout_err)
  );

  function automatic stim_t mk(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic ur, input logic br,
                               input logic jp, input logic acc, input logic rdy);
    stim_t s;
    s = '{mr, ert, rs, rt, ur, br, jp, acc, rdy};
    return s;
  endfunction

  function automatic logic [6:0] outs();
    return {PC_write, IF_ID_write, IF_Flush, ID_Hazard_lwstall, ID_Hazard_Branch,
            pipe_hold, mem_timeout_err};
  endfunction

  task automatic apply(input stim_t s, input logic [6:0] e);
    ID_EX_MemRead    = s.mr;
    ID_EX_RegisterRt = s.ert;
    IF_ID_RegisterRs = s.rs;
    IF_ID_RegisterRt = s.rt;
    IF_ID_UsesRt     = s.ur;
    MEM_BranchTaken  = s.br;
    MEM_Jump         = s.jp;
    MEM_Access       = s.acc;
    dmem_ready       = s.rdy;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [6:0] e;
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), DEF);
    #3;
    e = exp_q.pop_front();
    vectors++;
    if (outs() !== e) begin
      miscompares++;
      $display("FAIL reset_hold got %b want %b", outs(), e);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), DEF);
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (outs() !== e) begin
      miscompares++;
      $display("FAIL reset_idle got %b want %b", outs(), e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    stim_t st [6];
    logic [6:0] ex [6];
    logic [6:0] e;
    st = '{mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)};
    ex = '{LWS, DEF, LWS, DEF, LWS, LWS};
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL load_use[%0d] got %b want %b", i, outs(), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_no_stall();
    stim_t st [4];
    logic [6:0] ex [4];
    logic [6:0] e;
    st = '{mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
    ex = '{DEF, DEF, DEF, DEF};
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL no_stall[%0d] got %b want %b", i, outs(), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    stim_t st [10];
    logic [6:0] ex [10];
    logic [6:0] e;
    st = '{mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
           mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    // Second jump lands on the last flush cycle and reloads the count.
    ex = '{FLS, FLS, FLS, DEF, FLS, FLS, FLS, FLS, FLS, DEF};
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL branch[%0d] got %b want %b", i, outs(), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t st [15];
    logic [6:0] ex [15];
    logic [6:0] e;
    st = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    // Jump held through the wait flushes only after release; a wait inside
    // a flush resumes the remaining two flush cycles afterwards.
    ex = '{HLD, HLD, HLD, HLD, DEF, FLS, FLS, FLS, DEF,
           FLS, HLD, DEF, FLS, FLS, DEF};
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL mem_wait[%0d] got %b want %b", i, outs(), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    stim_t st [9];
    logic [6:0] ex [9];
    logic [6:0] e;
    st = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    ex = '{HLD, HLD, HLD, HLD, HLD, DEF, DEF | ERR, LWS | ERR, DEF | ERR};
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL timeout[%0d] got %b want %b", i, outs(), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    stim_t idle;
    idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      // k=0 enters FLUSH via a branch, k=1 enters MEMWAIT via a stalled access.
      if (k == 0) begin
        apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), FLS | ERR);
      end else begin
        apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), HLD);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL arst_enter[%0d] got %b want %b", k, outs(), e);
      end
      @(posedge clk);
      #1;
      apply(idle, (k == 0) ? (FLS | ERR) : HLD);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL arst_mid[%0d] got %b want %b", k, outs(), e);
      end
      rst = 1'b1;
      exp_q.push_back(DEF);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (outs() !== e) begin
        miscompares++;
        $display("FAIL arst_now[%0d] got %b want %b", k, outs(), e);
      end
`ifdef HAZARD_STATS_EN
      vectors++;
      if ({lwstall_count, flush_count, memwait_count} !== 96'd0) begin
        miscompares++;
        $display("FAIL arst_stats[%0d] got %h %h %h want 0", k, lwstall_count, flush_count, memwait_count);
      end
`endif
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
    end
    apply(idle, DEF);
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (outs() !== e) begin
      miscompares++;
      $display("FAIL arst_after got %b want %b", outs(), e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
